hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Parametrised pipeline hazard controller for the 5-stage OTTER core, sitting beside the ID stage. It generates PC/IF_ID write enables, ID_EX bubble insertion and stage flushes. Hazard sources:
- load-use data hazards, with a configurable multi-cycle load stall and x0/unused-operand filtering
- taken branches/jumps resolved in EX
- a data-memory busy handshake that freezes the whole pipeline

## Interface
Parameters:
- REG_ADDR_W, default 5: register index width.
- LOAD_STALL_CYCLES, default 1: total stall cycles per load-use hazard; legal range 1..15.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RD  in  REG_ADDR_W  destination register of instruction in EX.
- IF_ID_RS1, IF_ID_RS2  in  REG_ADDR_W  source registers of instruction in ID.
- IF_ID_RS1_USED, IF_ID_RS2_USED  in  1  the ID instruction actually reads that source.
- EX_BRANCH_TAKEN  in  1  branch/jump in EX resolved taken this cycle.
- MEM_BUSY  in  1  data memory not ready; the pipeline must freeze.
- PCWrite  out  1  PC register load enable.
- IF_ID_Write  out  1  IF_ID register load enable.
- select  out  1  1 = pass decoded control into ID_EX; 0 = insert bubble (all-zero control).
- IF_ID_Flush  out  1  clear IF_ID to NOP on next edge.
- ID_EX_Flush  out  1  clear ID_EX to bubble on next edge.
- PIPE_HOLD  out  1  hold ID_EX, EX_MEM, MEM_WB registers.
- STALL_CNT, FLUSH_CNT  out  32  performance counters; present only with HAZARD_PERF_CNT_EN.

## Operation
- Hazard term: `hz = ID_EX_MemRead && ID_EX_RD != 0 && ((RS1_USED && RS1 == RD) || (RS2_USED && RS2 == RD))`.
- States: RUN and LOAD_STALL. The LOAD_STALL down-counter has width ceil(log2(LOAD_STALL_CYCLES)), minimum 1.
- Priority within a cycle, highest first:

1. **RST_N low**
   - Outputs forced: PCWrite=0, IF_ID_Write=0, select=0, IF_ID_Flush=1, ID_EX_Flush=1, PIPE_HOLD=0.
   - State set to RUN, counter 0, perf counters 0.
2. **MEM_BUSY=1**
   - Outputs: PIPE_HOLD=1, PCWrite=0, IF_ID_Write=0, select=1, both flushes 0.
   - State and counter frozen.
   - Pending branch/hazard is not acted on; it is re-evaluated after release.
3. **EX_BRANCH_TAKEN=1**
   - Outputs: PCWrite=1, IF_ID_Write=1, select=0, IF_ID_Flush=1, ID_EX_Flush=1.
   - Next state RUN; any LOAD_STALL is aborted and the counter cleared.
   - A coincident hz is ignored, because the ID instruction is squashed.
4. **RUN with hz=1**
   - Outputs: PCWrite=0, IF_ID_Write=0, select=0.
   - If LOAD_STALL_CYCLES>1: next state LOAD_STALL, counter = LOAD_STALL_CYCLES-2.
5. **LOAD_STALL**
   - Outputs: PCWrite=0, IF_ID_Write=0, select=0.
   - Counter 0 → next state RUN; otherwise decrement.
6. **Default**
   - Outputs: PCWrite=1, IF_ID_Write=1, select=1, flushes 0, PIPE_HOLD=0.
- With LOAD_STALL_CYCLES=1 the FSM never leaves RUN. Behaviour is then a single-cycle load-use stall with x0/unused filtering.
- hz is not evaluated in LOAD_STALL. ID_EX holds a bubble, so no re-trigger occurs.

## Timing
- All outputs are combinational from the inputs plus registered state. The path from hz to stall has zero latency.
- Stall length is exactly LOAD_STALL_CYCLES cycles of PCWrite=0 per hazard, excluding cycles frozen by MEM_BUSY.
- A flush lasts exactly the cycle EX_BRANCH_TAKEN is high. The two-instruction squash is achieved by flushing IF_ID and ID_EX together.
- Reset assertion takes effect immediately (asynchronous), including mid-LOAD_STALL. Deassertion is synchronised externally; the first post-reset cycle is RUN.
- Back-to-back hazards: a new hz in the first RUN cycle after LOAD_STALL starts a new stall with no gap.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - STALL_CNT increments every cycle PCWrite=0 with MEM_BUSY=0 and RST_N high.
  - FLUSH_CNT increments every cycle IF_ID_Flush=1 with RST_N high.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- LOAD_STALL_CYCLES=1, MemRead=1, RD=5, RS1=5, RS1_USED=1 → one cycle of PCWrite=0/IF_ID_Write=0/select=0, then all 1.
- RD=0 matching RS1=0, or RD=7 matching RS2=7 with RS2_USED=0 → no stall.
- LOAD_STALL_CYCLES=3 hazard, with MEM_BUSY high during the second stall cycle:
  - PCWrite=0 for 4 cycles; PIPE_HOLD=1 only in the busy cycle.
  - With perf counters enabled, STALL_CNT=3.
- LOAD_STALL_CYCLES=3, EX_BRANCH_TAKEN pulsed in the second stall cycle → that cycle shows flushes=1 and PCWrite=1; the next cycle is RUN with PCWrite=1.
- EX_BRANCH_TAKEN=1 with a coincident hz → IF_ID_Flush=ID_EX_Flush=1, PCWrite=1, no stall in the following cycle. With MEM_BUSY also high → flushes 0, PIPE_HOLD=1.
- RST_N driven low mid-LOAD_STALL → outputs take reset values immediately. After release → RUN, PCWrite=1, counters 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline hazard controller for the 5-stage OTTER core, placed beside ID.
// Produces PC / IF_ID write enables, the ID_EX bubble select and stage
// flushes from three sources:
//   - load-use hazards, stretched to LOAD_STALL_CYCLES cycles
//   - taken branches/jumps resolved in EX (two-instruction squash)
//   - a data-memory busy handshake that freezes the whole pipeline
// Optional build macro HAZARD_PERF_CNT_EN adds saturating STALL_CNT and
// FLUSH_CNT performance counters; without it those ports do not exist.

module hazard_control_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1   // legal range 1..15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RD,
  input  logic [REG_ADDR_W-1:0] IF_ID_RS1,
  input  logic [REG_ADDR_W-1:0] IF_ID_RS2,
  input  logic                  IF_ID_RS1_USED,
  input  logic                  IF_ID_RS2_USED,
  input  logic                  EX_BRANCH_TAKEN,
  input  logic                  MEM_BUSY,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  select,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic                  PIPE_HOLD
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           STALL_CNT,
  output logic [31:0]           FLUSH_CNT
`endif
);

  // The first stall cycle is spent in RUN, so LOAD_STALL covers the
  // remaining LOAD_STALL_CYCLES-1 cycles, counting down to zero.
  localparam int CNT_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hz;

  // Load-use hazard: EX load writes a non-x0 register that ID really reads.
  assign hz = ID_EX_MemRead && (ID_EX_RD != '0) &&
              ((IF_ID_RS1_USED && (IF_ID_RS1 == ID_EX_RD)) ||
               (IF_ID_RS2_USED && (IF_ID_RS2 == ID_EX_RD)));

  // State register: FSM state and stall down-counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: busy freezes, branch aborts, hazard enters stall.
  always_comb begin
    // NOTE: defaulting every always_comb output first prevents latch
    // inference on paths that do not assign it.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!MEM_BUSY) begin
      if (EX_BRANCH_TAKEN) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else if (state == RUN) begin
        if (hz && (LOAD_STALL_CYCLES > 1)) begin
          state_nxt = LOAD_STALL;
          cnt_nxt   = CNT_LOAD;
        end
      end else if (cnt == '0) begin
        state_nxt = RUN;
      end else begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end
  end

  // Output logic: prioritised reset > busy > branch > stall > run.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    select      = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    PIPE_HOLD   = 1'b0;
    if (!RST_N) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      select      = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (MEM_BUSY) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      PIPE_HOLD   = 1'b1;
    end else if (EX_BRANCH_TAKEN) begin
      // Squash both younger instructions; a coincident hazard is moot.
      select      = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if ((state == LOAD_STALL) || hz) begin
      // hz is not consulted in LOAD_STALL: ID_EX already holds a bubble.
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      select      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters: saturating stall and flush cycle counts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (!PCWrite && !MEM_BUSY && (STALL_CNT != '1)) STALL_CNT <= STALL_CNT + 32'd1;
      if (IF_ID_Flush && (FLUSH_CNT != '1))           FLUSH_CNT <= FLUSH_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit. Two instances share one stimulus:
// dut1 with LOAD_STALL_CYCLES=1 and dut3 with LOAD_STALL_CYCLES=3.
// The reference model tracks "stall cycles still owed" per instance and
// derives the expected control bundle from the priority rules.
// Define HAZARD_PERF_CNT_EN to also check the performance counters.

module tb_hazard_control_unit;

  localparam int AW = 5;

  // Expected bundle {PCWrite, IF_ID_Write, select, IF_ID_Flush, ID_EX_Flush, PIPE_HOLD}
  localparam logic [5:0] OUT_RST   = 6'b000110;
  localparam logic [5:0] OUT_BUSY  = 6'b001001;
  localparam logic [5:0] OUT_FLUSH = 6'b110110;
  localparam logic [5:0] OUT_STALL = 6'b000000;
  localparam logic [5:0] OUT_RUN   = 6'b111000;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          mem_read = 1'b0;
  logic [AW-1:0] rd = '0, rs1 = '0, rs2 = '0;
  logic          rs1_used = 1'b0, rs2_used = 1'b0, branch = 1'b0, busy = 1'b0;

  logic pcw1, ifw1, sel1, iff1, idf1, hold1;
  logic pcw3, ifw3, sel3, iff3, idf3, hold3;
  logic [5:0] out1, out3;
  assign out1 = {pcw1, ifw1, sel1, iff1, idf1, hold1};
  assign out3 = {pcw3, ifw3, sel3, iff3, idf3, hold3};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  int tests = 0;
  int fails = 0;

  // Model state
  int          rem1 = 0, rem3 = 0;
  logic [31:0] m_sc1 = '0, m_fc1 = '0, m_sc3 = '0, m_fc3 = '0;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .ID_EX_MemRead(mem_read), .ID_EX_RD(rd),
    .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_RS1_USED(rs1_used),
    .IF_ID_RS2_USED(rs2_used), .EX_BRANCH_TAKEN(branch), .MEM_BUSY(busy),
    .PCWrite(pcw1), .IF_ID_Write(ifw1), .select(sel1), .IF_ID_Flush(iff1),
    .ID_EX_Flush(idf1), .PIPE_HOLD(hold1)
`ifdef HAZARD_PERF_CNT_EN
    , .STALL_CNT(sc1), .FLUSH_CNT(fc1)
`endif
  );

  hazard_control_unit #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .ID_EX_MemRead(mem_read), .ID_EX_RD(rd),
    .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_RS1_USED(rs1_used),
    .IF_ID_RS2_USED(rs2_used), .EX_BRANCH_TAKEN(branch), .MEM_BUSY(busy),
    .PCWrite(pcw3), .IF_ID_Write(ifw3), .select(sel3), .IF_ID_Flush(iff3),
    .ID_EX_Flush(idf3), .PIPE_HOLD(hold3)
`ifdef HAZARD_PERF_CNT_EN
    , .STALL_CNT(sc3), .FLUSH_CNT(fc3)
`endif
  );

  // ---------------- reference model ----------------
  function automatic bit model_hz();
    return mem_read && (rd != '0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  function automatic logic [5:0] model_out(input int rem);
    if (!RST_N)             return OUT_RST;
    if (busy)               return OUT_BUSY;
    if (branch)             return OUT_FLUSH;
    if (rem > 0 || model_hz()) return OUT_STALL;
    return OUT_RUN;
  endfunction

  task automatic model_step(inout int rem, inout logic [31:0] sc, inout logic [31:0] fc,
                            input int n);
    logic [5:0] o;
    o = model_out(rem);
    if (!RST_N) begin
      rem = 0; sc = '0; fc = '0;
    end else begin
      if (!o[5] && !busy && sc != 32'hFFFF_FFFF) sc = sc + 32'd1;
      if (o[2] && fc != 32'hFFFF_FFFF)           fc = fc + 32'd1;
      if (!busy) begin
        if (branch)          rem = 0;
        else if (rem > 0)    rem = rem - 1;
        else if (model_hz()) rem = n - 1;
      end
    end
  endtask

  // Advance one clock: model samples the same pre-edge inputs as the DUTs.
  task automatic tick();
    @(posedge CLK);
    model_step(rem1, m_sc1, m_fc1, 1);
    model_step(rem3, m_sc3, m_fc3, 3);
    #1;
  endtask

  task automatic set_idle();
    mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; branch = 1'b0; busy = 1'b0;
  endtask

  task automatic drive_hz();
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
    rs2 = 5'd2; rs2_used = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    tests++;
    if (out1 !== OUT_RST) begin fails++; $display("FAIL reset n1 got %b want %b", out1, OUT_RST); end
    tests++;
    if (out3 !== OUT_RST) begin fails++; $display("FAIL reset n3 got %b want %b", out3, OUT_RST); end
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    tests++;
    if (out3 !== OUT_RUN) begin fails++; $display("FAIL reset_release n3 got %b want %b", out3, OUT_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    if ({sc3, fc3} !== 64'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", sc3, fc3); end
`endif
    tick();
  endtask

  task automatic test_load_use();
    logic [5:0] want1 [5] = '{OUT_STALL, OUT_RUN, OUT_RUN, OUT_RUN, OUT_RUN};
    logic [5:0] want3 [5] = '{OUT_STALL, OUT_STALL, OUT_STALL, OUT_RUN, OUT_RUN};
    for (int i = 0; i < 5; i++) begin
      set_idle();
      if (i == 0) drive_hz();
      @(negedge CLK);
      tests++;
      if (out1 !== want1[i]) begin fails++; $display("FAIL load_use n1 cyc%0d got %b want %b", i, out1, want1[i]); end
      tests++;
      if (out3 !== want3[i]) begin fails++; $display("FAIL load_use n3 cyc%0d got %b want %b", i, out3, want3[i]); end
      tick();
    end
  endtask

  task automatic test_filter();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      mem_read = 1'b1;
      if (i == 0) begin rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1; end
      else begin rd = 5'd7; rs2 = 5'd7; rs2_used = 1'b0; rs1 = 5'd3; rs1_used = 1'b1; end
      @(negedge CLK);
      tests++;
      if (out1 !== OUT_RUN) begin fails++; $display("FAIL filter n1 case%0d got %b want %b", i, out1, OUT_RUN); end
      tests++;
      if (out3 !== OUT_RUN) begin fails++; $display("FAIL filter n3 case%0d got %b want %b", i, out3, OUT_RUN); end
      tick();
    end
  endtask

  task automatic test_busy_in_stall();
    logic [5:0] want1 [6] = '{OUT_STALL, OUT_BUSY, OUT_RUN, OUT_RUN, OUT_RUN, OUT_RUN};
    logic [5:0] want3 [6] = '{OUT_STALL, OUT_BUSY, OUT_STALL, OUT_STALL, OUT_RUN, OUT_RUN};
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc3_start;
    sc3_start = sc3;
`endif
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i == 0) drive_hz();
      if (i == 1) busy = 1'b1;
      @(negedge CLK);
      tests++;
      if (out1 !== want1[i]) begin fails++; $display("FAIL busy_stall n1 cyc%0d got %b want %b", i, out1, want1[i]); end
      tests++;
      if (out3 !== want3[i]) begin fails++; $display("FAIL busy_stall n3 cyc%0d got %b want %b", i, out3, want3[i]); end
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    if (sc3 - sc3_start !== 32'd3) begin fails++; $display("FAIL busy_stall_cnt got %0d want 3", sc3 - sc3_start); end
`endif
  endtask

  task automatic test_branch_in_stall();
    logic [5:0] want1 [3] = '{OUT_STALL, OUT_FLUSH, OUT_RUN};
    logic [5:0] want3 [3] = '{OUT_STALL, OUT_FLUSH, OUT_RUN};
    for (int i = 0; i < 3; i++) begin
      set_idle();
      if (i == 0) drive_hz();
      if (i == 1) branch = 1'b1;
      @(negedge CLK);
      tests++;
      if (out1 !== want1[i]) begin fails++; $display("FAIL branch_stall n1 cyc%0d got %b want %b", i, out1, want1[i]); end
      tests++;
      if (out3 !== want3[i]) begin fails++; $display("FAIL branch_stall n3 cyc%0d got %b want %b", i, out3, want3[i]); end
      tick();
    end
  endtask

  task automatic test_branch_hz();
    logic [5:0] want [4] = '{OUT_FLUSH, OUT_RUN, OUT_BUSY, OUT_RUN};
    for (int i = 0; i < 4; i++) begin
      set_idle();
      if (i == 0 || i == 2) begin drive_hz(); branch = 1'b1; end
      if (i == 2) busy = 1'b1;
      @(negedge CLK);
      tests++;
      if (out1 !== want[i]) begin fails++; $display("FAIL branch_hz n1 cyc%0d got %b want %b", i, out1, want[i]); end
      tests++;
      if (out3 !== want[i]) begin fails++; $display("FAIL branch_hz n3 cyc%0d got %b want %b", i, out3, want[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      if (i < 6) drive_hz();
      @(negedge CLK);
      tests++;
      if (out1 !== ((i < 6) ? OUT_STALL : OUT_RUN)) begin fails++; $display("FAIL back_to_back n1 cyc%0d got %b", i, out1); end
      tests++;
      if (out3 !== ((i < 6) ? OUT_STALL : OUT_RUN)) begin fails++; $display("FAIL back_to_back n3 cyc%0d got %b", i, out3); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    drive_hz();
    tick();
    set_idle();
    @(negedge CLK);
    tests++;
    if (out3 !== OUT_STALL) begin fails++; $display("FAIL rst_mid pre n3 got %b want %b", out3, OUT_STALL); end
    #2 RST_N = 1'b0;
    #1;
    tests++;
    if (out3 !== OUT_RST) begin fails++; $display("FAIL rst_mid async n3 got %b want %b", out3, OUT_RST); end
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    tests++;
    if (out3 !== OUT_RUN) begin fails++; $display("FAIL rst_mid release n3 got %b want %b", out3, OUT_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    if ({sc1, fc1, sc3, fc3} !== 128'd0) begin fails++; $display("FAIL rst_mid cnt got %0d/%0d/%0d/%0d want 0", sc1, fc1, sc3, fc3); end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      busy     = ($urandom_range(0, 7) == 0);
      branch   = ($urandom_range(0, 9) == 0);
      mem_read = ($urandom_range(0, 1) == 1);
      rd       = AW'($urandom_range(0, 3));
      rs1      = AW'($urandom_range(0, 3));
      rs2      = AW'($urandom_range(0, 3));
      rs1_used = ($urandom_range(0, 3) != 0);
      rs2_used = ($urandom_range(0, 1) == 1);
      @(negedge CLK);
      tests++;
      if (out1 !== model_out(rem1)) begin fails++; $display("FAIL random n1 cyc%0d got %b want %b", i, out1, model_out(rem1)); end
      tests++;
      if (out3 !== model_out(rem3)) begin fails++; $display("FAIL random n3 cyc%0d got %b want %b", i, out3, model_out(rem3)); end
      tick();
    end
    set_idle();
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    if ({sc1, fc1} !== {m_sc1, m_fc1}) begin fails++; $display("FAIL random cnt n1 got %0d/%0d want %0d/%0d", sc1, fc1, m_sc1, m_fc1); end
    tests++;
    if ({sc3, fc3} !== {m_sc3, m_fc3}) begin fails++; $display("FAIL random cnt n3 got %0d/%0d want %0d/%0d", sc3, fc3, m_sc3, m_fc3); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_filter();
    test_busy_in_stall();
    test_branch_in_stall();
    test_branch_hz();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
